// File: rtl/regfile_dump_if.sv
// Debug-dump bundle: start/status, register-file debug read port and outgoing byte stream.
// master = the dump engine; slave = the register file plus transmitter side.
interface regfile_dump_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] debug_address;
   logic                  debug_clock;
   logic [DATA_WIDTH-1:0] debug_data;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;

   modport master (
      input  start,
      output busy,
      output done,
      output debug_address,
      output debug_clock,
      input  debug_data,
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      output start,
      input  busy,
      input  done,
      input  debug_address,
      input  debug_clock,
      output debug_data,
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/regfile_dump.sv
// Register-file snapshot streamer: A5 header then every register MSB byte first; 7 cycles/register at full rate.
// tx_valid/tx_data hold until accepted; each stalled cycle in SYNC/SEND adds one cycle, nothing is dropped.
module regfile_dump #(
   parameter int         NUM_REGS   = 32,
   parameter int         ADDR_WIDTH = 5,
   parameter int         DATA_WIDTH = 32,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input logic           clock,
   input logic           reset,
   regfile_dump_if.master dbg
);
   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_ADDR, S_FALL, S_CAPT, S_SEND, S_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

   state_t                r_state,     w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_index,     w_index_nxt;
   logic [1:0]            r_byte,      w_byte_nxt;
   logic [DATA_WIDTH-1:0] r_cap,       w_cap_nxt;
   logic [7:0]            r_tx_data,   w_tx_data_nxt;
   logic                  r_tx_valid,  w_tx_valid_nxt;
   logic                  r_busy,      w_busy_nxt;
   logic                  r_done,      w_done_nxt;
   logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
   logic                  r_dclk,      w_dclk_nxt;
   logic                  w_accept;

   assign w_accept = r_tx_valid & dbg.tx_ready;

   // Outputs are computed for the state being entered so every port comes straight from a flop.
   always_comb begin
      w_state_nxt    = r_state;
      w_index_nxt    = r_index;
      w_byte_nxt     = r_byte;
      w_cap_nxt      = r_cap;
      w_tx_data_nxt  = r_tx_data;
      w_tx_valid_nxt = r_tx_valid;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_addr_nxt     = r_addr;
      w_dclk_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (dbg.start) begin
               w_state_nxt    = S_SYNC;
               w_index_nxt    = '0;
               w_busy_nxt     = 1'b1;
               w_tx_valid_nxt = 1'b1;
               w_tx_data_nxt  = SYNC_BYTE;
               w_addr_nxt     = '0;
            end
         end
         S_SYNC: begin
            if (w_accept) begin
               w_state_nxt    = S_ADDR;
               w_tx_valid_nxt = 1'b0;
               w_tx_data_nxt  = '0;
               w_addr_nxt     = r_index;
               w_dclk_nxt     = 1'b1;
            end
         end
         S_ADDR: w_state_nxt = S_FALL;
         S_FALL: begin
            // One full clock has elapsed since the debug_clock falling edge.
            w_state_nxt = S_CAPT;
            w_cap_nxt   = dbg.debug_data;
         end
         S_CAPT: begin
            w_state_nxt    = S_SEND;
            w_byte_nxt     = 2'd0;
            w_tx_valid_nxt = 1'b1;
            w_tx_data_nxt  = r_cap[DATA_WIDTH-1 -: 8];
         end
         S_SEND: begin
            if (w_accept) begin
               if (r_byte != 2'd3) begin
                  w_byte_nxt    = r_byte + 2'd1;
                  w_cap_nxt     = {r_cap[DATA_WIDTH-9:0], 8'h00};
                  w_tx_data_nxt = r_cap[DATA_WIDTH-9 -: 8];
               end else begin
                  w_tx_valid_nxt = 1'b0;
                  w_tx_data_nxt  = '0;
                  if (r_index == LAST_IDX) begin
                     w_state_nxt = S_DONE;
                     w_busy_nxt  = 1'b0;
                     w_done_nxt  = 1'b1;
                     w_addr_nxt  = '0;
                  end else begin
                     w_state_nxt = S_ADDR;
                     w_index_nxt = r_index + ADDR_WIDTH'(1);
                     w_addr_nxt  = r_index + ADDR_WIDTH'(1);
                     w_dclk_nxt  = 1'b1;
                  end
               end
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_index    <= '0;
         r_byte     <= '0;
         r_cap      <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_addr     <= '0;
         r_dclk     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_index    <= w_index_nxt;
         r_byte     <= w_byte_nxt;
         r_cap      <= w_cap_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_valid <= w_tx_valid_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_addr     <= w_addr_nxt;
         r_dclk     <= w_dclk_nxt;
      end
   end

   assign dbg.busy          = r_busy;
   assign dbg.done          = r_done;
   assign dbg.debug_address = r_addr;
   assign dbg.debug_clock   = r_dclk;
   assign dbg.tx_data       = r_tx_data;
   assign dbg.tx_valid      = r_tx_valid;
endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: register-file model on the debug port, byte scoreboard,
// handshake/debug_clock monitors and a single checking task.
module tb_regfile_dump;
   logic clock;
   logic reset;

   regfile_dump_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

   regfile_dump dut (
      .clock (clock),
      .reset (reset),
      .dbg   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] regs [32];
   logic [7:0]  q [$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          done_cnt, done_cyc, rises, falls, addr_err, stable_viol;
   logic        busy_at_done;
   bit          rnd_ready = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int i);
      logic [31:0] w;
      if (i == 0) return 8'hA5;
      w = regs[(i - 1) / 4];
      return w[8 * (3 - ((i - 1) % 4)) +: 8];
   endfunction

   // Register file debug port: loads on the falling edge of debug_clock.
   always @(negedge bus.debug_clock) bus.debug_data = regs[bus.debug_address];

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      #2;
      bus.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitors sample mid-cycle, between the ready update and the next rising edge.
   logic       prev_dclk = 1'b0;
   logic       pend = 1'b0;
   logic [7:0] pend_dat = 8'h00;
   int         win = 0;
   int         win_k = 0;
   always @(negedge clock) begin
      if (reset) begin
         pend = 1'b0;
      end else begin
         if (pend && (!bus.tx_valid || bus.tx_data !== pend_dat)) stable_viol++;
         pend     = bus.tx_valid && !bus.tx_ready;
         pend_dat = bus.tx_data;
         if (bus.tx_valid && bus.tx_ready) q.push_back(bus.tx_data);
      end
      if (bus.debug_clock && !prev_dclk) begin
         win_k = rises;
         rises++;
         win = 3;
      end
      if (!bus.debug_clock && prev_dclk) falls++;
      if (win > 0) begin
         if (int'(bus.debug_address) != win_k) addr_err++;
         win--;
      end
      prev_dclk = bus.debug_clock;
      if (bus.done) begin
         done_cnt++;
         done_cyc     = cyc - start_cyc;
         busy_at_done = bus.busy;
      end
   end

   task automatic clear_stats();
      q.delete();
      done_cnt = 0; done_cyc = 0; rises = 0; falls = 0;
      addr_err = 0; stable_viol = 0; busy_at_done = 1'b1;
   endtask

   task automatic pulse_start();
      @(posedge clock); #2;
      bus.start = 1'b1;
      @(posedge clock); #2;
      bus.start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input string tag);
      int i;
      for (i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clock);
      check_val({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
      repeat (3) @(posedge clock);
   endtask

   task automatic check_stream(input string tag);
      int e = 0;
      for (int i = 0; i < q.size(); i++) if (q[i] !== exp_byte(i)) e++;
      check_val({tag, "_len"}, 64'(q.size()), 64'd129);
      check_val({tag, "_bytes"}, 64'(e), 64'd0);
      check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check_val({tag, "_stable"}, 64'(stable_viol), 64'd0);
      check_val({tag, "_dclk_rise"}, 64'(rises), 64'd32);
      check_val({tag, "_dclk_fall"}, 64'(falls), 64'd32);
      check_val({tag, "_addr_win"}, 64'(addr_err), 64'd0);
      check_val({tag, "_busy_in_done"}, 64'(busy_at_done), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] = 32'(i);
      clear_stats();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      check_val("rst_done", 64'(bus.done), 64'd0);
      check_val("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
      check_val("rst_tx_data", 64'(bus.tx_data), 64'd0);
      check_val("rst_dclk", 64'(bus.debug_clock), 64'd0);
      check_val("rst_addr", 64'(bus.debug_address), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Full-rate snapshot of the reset register file.
      clear_stats();
      pulse_start();
      check_val("t1_busy_after_start", 64'(bus.busy), 64'd1);
      check_val("t1_sync_valid", 64'(bus.tx_valid), 64'd1);
      check_val("t1_sync_data", 64'(bus.tx_data), 64'hA5);
      wait_done("t1");
      check_stream("t1");
      check_val("t1_done_latency", 64'(done_cyc), 64'd225);
      check_val("t1_byte0", 64'(q[0]), 64'hA5);
      check_val("t1_byte4", 64'(q[4]), 64'h00);
      check_val("t1_byte8", 64'(q[8]), 64'h01);
      check_val("t1_byte128", 64'(q[128]), 64'h1F);
      check_val("t1_idle_busy", 64'(bus.busy), 64'd0);

      // Register 7 rewritten; its four bytes sit at stream positions 29..32.
      regs[7] = 32'hDEADBEEF;
      clear_stats();
      pulse_start();
      wait_done("t2");
      check_stream("t2");
      check_val("t2_byte28", 64'(q[28]), 64'h06);
      check_val("t2_byte29", 64'(q[29]), 64'hDE);
      check_val("t2_byte30", 64'(q[30]), 64'hAD);
      check_val("t2_byte31", 64'(q[31]), 64'hBE);
      check_val("t2_byte32", 64'(q[32]), 64'hEF);
      check_val("t2_byte33", 64'(q[33]), 64'h00);

      // Random backpressure: same stream, held data while stalled.
      rnd_ready = 1'b1;
      clear_stats();
      pulse_start();
      wait_done("t3");
      check_stream("t3");
      check_val("t3_stalled_latency", 64'(done_cyc > 225), 64'd1);
      rnd_ready = 1'b0;

      // A second start while register 10 is being read is ignored.
      clear_stats();
      pulse_start();
      begin
         int i;
         for (i = 0; i < 2000 && !(bus.debug_clock && bus.debug_address == 5'd10); i++) @(posedge clock);
         check_val("t4_reached_reg10", 64'(bus.debug_address), 64'd10);
      end
      #2 bus.start = 1'b1;
      @(posedge clock); #2;
      bus.start = 1'b0;
      wait_done("t4");
      repeat (20) @(posedge clock);
      check_stream("t4");
      check_val("t4_idle_after", 64'(bus.busy), 64'd0);

      // Reset while register 20 byte 2 (stream byte 83) is on the bus.
      clear_stats();
      pulse_start();
      begin
         int i;
         for (i = 0; i < 2000 && q.size() < 83; i++) begin
            @(posedge clock); #3;
         end
         check_val("t5_at_byte83", 64'(q.size()), 64'd83);
      end
      check_val("t5_pre_valid", 64'(bus.tx_valid), 64'd1);
      check_val("t5_pre_data", 64'(bus.tx_data), 64'h00);
      reset = 1'b1;
      #1;
      check_val("t5_rst_valid", 64'(bus.tx_valid), 64'd0);
      check_val("t5_rst_busy", 64'(bus.busy), 64'd0);
      check_val("t5_rst_dclk", 64'(bus.debug_clock), 64'd0);
      check_val("t5_rst_addr", 64'(bus.debug_address), 64'd0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (10) @(posedge clock);
      check_val("t5_no_done", 64'(done_cnt), 64'd0);
      clear_stats();
      pulse_start();
      wait_done("t5b");
      check_stream("t5b");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
